ram_burst_master: RTL and testbench
===================================

Name: ram_burst_master

Overview:
- Initiator for the team's single-port block RAM: synchronous write, registered read address, combinational read data from the registered address.
- Accepts one burst command at a time: address, length, direction.
- Sequences the RAM's ADDR/WE/data_in pins. Streams write data in from a producer and read data out to a consumer, each with valid/ready handshakes.
- Sits between a core's local load/store logic and its private RAM in the ring-network multicore.

Parameters:
AW, 3, RAM address width; RAM depth is 2^AW words
DW, 4, RAM data width

Ports:
CLK  in  1  clock; all state updates on rising edge
RST_N  in  1  asynchronous active-low reset
req_valid  in  1  burst command valid
req_ready  out  1  burst command accepted when high with req_valid
req_write  in  1  1 = write burst, 0 = read burst
req_addr  in  AW  start address
req_len  in  AW  beats minus one (0 = 1 beat, 2^AW-1 = whole RAM)
wr_data  in  DW  write beat data
wr_valid  in  1  write beat valid
wr_ready  out  1  write beat accepted when high with wr_valid
rd_data  out  DW  read beat data
rd_valid  out  1  read beat valid
rd_ready  in  1  consumer accepts read beat
done  out  1  one-cycle pulse after the final beat of a burst
ram_addr  out  AW  to RAM ADDR
ram_we  out  1  to RAM WE
ram_din  out  DW  to RAM data_in
ram_dout  in  DW  from RAM data_out

Behaviour:
- Registers: state, cur_addr (AW), cnt (AW), done.
- Reset (RST_N low, takes effect immediately):
  - state=IDLE, cur_addr=0, cnt=0, done=0.
  - While reset is held: ram_we=0, wr_ready=0, rd_valid=0.
- Combinational outputs:
  - ram_addr=cur_addr.
  - ram_din=wr_data.
  - ram_we = (state==WR) & wr_valid.
  - wr_ready = (state==WR).
  - rd_valid = (state==RD_DATA).
  - rd_data = ram_dout.
  - req_ready = (state==IDLE).
- IDLE:
  - On req_valid: cur_addr<=req_addr, cnt<=req_len.
  - Next state is WR if req_write=1, else RD_WAIT.
  - Command fields are sampled only in this cycle; later changes are ignored.
- WR:
  - Each cycle with wr_valid, the RAM writes wr_data at cur_addr on that edge.
  - If cnt==0: go to IDLE and set done<=1.
  - Else: cur_addr<=cur_addr+1, cnt<=cnt-1.
  - wr_valid low means no write and no state change.
  - Throughput: 1 beat/cycle.
- RD_WAIT:
  - Exactly one cycle, during which the RAM registers ram_addr.
  - Unconditionally goes to RD_DATA.
- RD_DATA:
  - rd_valid=1; rd_data holds mem[cur_addr]. ram_addr stays constant, so data is stable under backpressure.
  - On rd_ready with cnt==0: go to IDLE, done<=1.
  - On rd_ready with cnt!=0: cur_addr<=cur_addr+1, cnt<=cnt-1, go to RD_WAIT.
  - Throughput: 1 beat per 2 cycles.
  - Read latency: first rd_valid occurs 2 cycles after command accept.
- done:
  - High for exactly one cycle, the first IDLE cycle after the last beat.
  - A new command may be accepted in that same cycle.
- Address wrap: cur_addr+1 is modulo 2^AW, so 7 wraps to 0 at AW=3. A burst never stops early on wrap.
- Beat count: exactly req_len+1 beats per burst; no extra writes or reads are presented.
- No transaction overlap: wr_ready is never high during a read burst and rd_valid is never high during a write burst.
- Reset mid-burst aborts immediately. Writes already completed remain in the RAM. No done pulse is issued for an aborted burst.
- Writes to an address followed by a read of the same address in a later burst return the new data.

Test Plan:
- Single write then single read:
  - Write addr 3, len 0, data 4'hA; done pulses the cycle after the beat.
  - Read addr 3, len 0: rd_valid rises 2 cycles after accept with rd_data=4'hA, done after rd_ready.
- Wrapping write burst:
  - Write addr 6, len 3, data A,B,C,D with wr_valid continuous.
  - ram_we on 4 consecutive cycles at ram_addr 6,7,0,1.
  - A subsequent read burst addr 6, len 3 returns A,B,C,D in order.
- Read backpressure:
  - Read addr 0, len 1; hold rd_ready=0 for 5 cycles.
  - rd_valid and rd_data stay stable (mem[0]) throughout.
  - After release, second beat is mem[1]; exactly 2 handshakes, one done pulse.
- Write gaps: write len 2 with wr_valid toggled 1,0,0,1,0,1. Exactly 3 ram_we pulses at addresses +0, +1, +2 and no writes in the gap cycles.
- Full-memory read: read addr 0, len 7 after filling RAM with 0..7. Returns 0..7, rd_valid asserted every other cycle with rd_ready=1, one done pulse.
- Reset mid-burst:
  - Assert RST_N=0 after 2 beats of a 4-beat write.
  - ram_we, wr_ready and rd_valid drop immediately, no done pulse, req_ready=1 after release.
  - The first 2 addresses hold the new data; the others are unchanged.

Source files
------------

// File: rtl/ram_burst_master_if.sv
// ram_burst_master_if: command, write-stream, read-stream and RAM pin bundle for the burst master.
// Latency: none, wires only.
// Backpressure: req_ready / wr_ready / rd_ready carry the valid-ready handshakes.
interface ram_burst_master_if #(
  parameter int AW = 3,
  parameter int DW = 4
);
  // burst command
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] req_len;
  // write beat stream from the producer
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  // read beat stream to the consumer
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  // end-of-burst pulse
  logic          done;
  // block RAM pins
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  // burst master side
  modport master (
    input  req_valid, req_write, req_addr, req_len,
    input  wr_data, wr_valid,
    input  rd_ready,
    input  ram_dout,
    output req_ready, wr_ready, rd_data, rd_valid, done,
    output ram_addr, ram_we, ram_din
  );

  // load/store logic and RAM side
  modport slave (
    output req_valid, req_write, req_addr, req_len,
    output wr_data, wr_valid,
    output rd_ready,
    output ram_dout,
    input  req_ready, wr_ready, rd_data, rd_valid, done,
    input  ram_addr, ram_we, ram_din
  );
endinterface

// File: rtl/ram_burst_master.sv
// ram_burst_master: sequences a single-port block RAM (sync write, registered read address) for one burst at a time.
// Latency: write 1 beat/cycle; first read beat 2 cycles after accept, then 1 beat per 2 cycles; done 1 cycle after last beat.
// Backpressure: wr_valid low stalls a write burst; rd_ready low holds the read beat stable; commands taken only in IDLE.
module ram_burst_master #(
  parameter int AW = 3,
  parameter int DW = 4
) (
  input logic                CLK,
  input logic                RST_N,
  ram_burst_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_WAIT = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  localparam logic [AW-1:0] ADDR_ONE = AW'(1);

  state_t        state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          last_beat;
  logic [DW-1:0] wr_dat;
  logic [DW-1:0] rd_dat;

  // remaining-beat counter reaches zero on the final beat of the burst
  assign last_beat = (cnt_q == '0);

  // state register; reset aborts any burst in flight without a done pulse
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  // next-state: sample the command in IDLE, advance address/count on each accepted beat
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          cur_addr_d = bus.req_addr;
          cnt_d      = bus.req_len;
          state_d    = bus.req_write ? WR : RD_WAIT;
        end
      end
      WR: begin
        if (bus.wr_valid) begin
          if (last_beat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cur_addr_d = cur_addr_q + ADDR_ONE;
            cnt_d      = cnt_q - ADDR_ONE;
          end
        end
      end
      // the RAM latches ram_addr during this cycle, so data is valid next cycle
      RD_WAIT: begin
        state_d = RD_DATA;
      end
      RD_DATA: begin
        if (bus.rd_ready) begin
          if (last_beat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cur_addr_d = cur_addr_q + ADDR_ONE;
            cnt_d      = cnt_q - ADDR_ONE;
            state_d    = RD_WAIT;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // outputs: pure decode of state plus pass-through data paths
  always_comb begin
    wr_dat        = bus.wr_data;
    rd_dat        = bus.ram_dout;
    bus.req_ready = (state_q == IDLE);
    bus.wr_ready  = (state_q == WR);
    bus.ram_we    = (state_q == WR) && bus.wr_valid;
    bus.ram_din   = wr_dat;
    // address held across RD_DATA keeps the RAM output stable under backpressure
    bus.ram_addr  = cur_addr_q;
    bus.rd_valid  = (state_q == RD_DATA);
    bus.rd_data   = rd_dat;
    bus.done      = done_q;
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master: drives directed and random bursts into ram_burst_master over a modelled block RAM.
// Latency: expectations derived per cycle from the burst rules (2-cycle read pipeline, 1-cycle done).
// Backpressure: exercises write gaps and read stalls, checking data stability.
module tb_ram_burst_master;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  ram_burst_master_if #(.AW(3), .DW(4)) bus ();

  ram_burst_master #(.AW(3), .DW(4)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // block RAM: synchronous write, registered read address, combinational read data
  logic [3:0] mem [8];
  logic [2:0] raddr_q;
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    raddr_q <= bus.ram_addr;
  end
  assign bus.ram_dout = mem[raddr_q];

  // reference memory contents as the burst rules say they should be
  logic [3:0] ref_mem [8];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // vmode: 0 continuous, 1 random, 2 fixed 1,0,0,1,0,1 pattern
  // dbase: <0 random data, else data = dbase + beat
  // abort_after: >=0 asserts reset once that many beats have been written
  task automatic do_write(input logic [2:0] a, input logic [2:0] len, input int vmode,
                          input int dbase, input int abort_after);
    int         beat = 0;
    int         cyc  = 0;
    logic       v;
    logic [3:0] d;
    logic [2:0] ea;
    logic [5:0] pat = 6'b101001;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = len;
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b0;
    #1 check_eq("wr_req_ready", 32'(bus.req_ready), 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = 3'($urandom);
    bus.req_len   = 3'($urandom);
    while (beat <= int'(len) && cyc < 100) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        default: v = pat[cyc % 6];
      endcase
      d  = (dbase < 0) ? 4'($urandom) : 4'(dbase + beat);
      ea = 3'(int'(a) + beat);
      if (abort_after >= 0 && beat == abort_after) begin
        rst_n        = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = d;
        #1;
        check_eq("abort_ram_we", 32'(bus.ram_we), 0);
        check_eq("abort_wr_ready", 32'(bus.wr_ready), 0);
        check_eq("abort_rd_valid", 32'(bus.rd_valid), 0);
        check_eq("abort_done", 32'(bus.done), 0);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.wr_valid = 1'b0;
        #1;
        check_eq("abort_req_ready", 32'(bus.req_ready), 1);
        check_eq("abort_done_rel", 32'(bus.done), 0);
        @(negedge clk);
        #1 check_eq("abort_no_done", 32'(bus.done), 0);
        @(negedge clk);
        return;
      end
      bus.wr_valid = v;
      bus.wr_data  = d;
      #1;
      check_eq("wr_wr_ready", 32'(bus.wr_ready), 1);
      check_eq("wr_rd_valid", 32'(bus.rd_valid), 0);
      check_eq("wr_req_ready_busy", 32'(bus.req_ready), 0);
      check_eq("wr_done_busy", 32'(bus.done), 0);
      check_eq("wr_ram_we", 32'(bus.ram_we), 32'(v));
      if (v) begin
        check_eq("wr_ram_addr", 32'(bus.ram_addr), 32'(ea));
        check_eq("wr_ram_din", 32'(bus.ram_din), 32'(d));
        ref_mem[ea] = d;
        beat++;
      end
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 100) check_eq("wr_timeout_beats", 32'(beat), 32'(int'(len) + 1));
    bus.wr_valid = 1'b0;
    bus.wr_data  = 4'($urandom);
    #1;
    check_eq("wr_done_pulse", 32'(bus.done), 1);
    check_eq("wr_end_req_ready", 32'(bus.req_ready), 1);
    check_eq("wr_end_wr_ready", 32'(bus.wr_ready), 0);
    check_eq("wr_end_ram_we", 32'(bus.ram_we), 0);
    @(negedge clk);
    #1 check_eq("wr_done_once", 32'(bus.done), 0);
    @(negedge clk);
  endtask

  // rmode: 0 always ready, 1 random ready, 2 stall the first beat for 'hold' valid cycles
  task automatic do_read(input logic [2:0] a, input logic [2:0] len, input int rmode, input int hold);
    int         beat    = 0;
    int         cyc     = 0;
    int         waited  = 0;
    logic       gap     = 1'b1;
    logic       rdy;
    logic [2:0] ea;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = a;
    bus.req_len   = len;
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b0;
    #1 check_eq("rd_req_ready", 32'(bus.req_ready), 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = 3'($urandom);
    bus.req_len   = 3'($urandom);
    while (beat <= int'(len) && cyc < 200) begin
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = !(beat == 0 && waited < hold);
      endcase
      bus.rd_ready = rdy;
      bus.wr_valid = 1'($urandom);
      ea = 3'(int'(a) + beat);
      #1;
      check_eq("rd_wr_ready", 32'(bus.wr_ready), 0);
      check_eq("rd_ram_we", 32'(bus.ram_we), 0);
      check_eq("rd_done_busy", 32'(bus.done), 0);
      check_eq("rd_req_ready_busy", 32'(bus.req_ready), 0);
      if (gap) begin
        check_eq("rd_valid_gap", 32'(bus.rd_valid), 0);
        gap = 1'b0;
      end else begin
        check_eq("rd_valid", 32'(bus.rd_valid), 1);
        check_eq("rd_data", 32'(bus.rd_data), 32'(ref_mem[ea]));
        if (rdy) begin
          beat++;
          gap = 1'b1;
        end else begin
          waited++;
        end
      end
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 200) check_eq("rd_timeout_beats", 32'(beat), 32'(int'(len) + 1));
    bus.rd_ready = 1'b0;
    bus.wr_valid = 1'b0;
    #1;
    check_eq("rd_done_pulse", 32'(bus.done), 1);
    check_eq("rd_end_req_ready", 32'(bus.req_ready), 1);
    check_eq("rd_end_rd_valid", 32'(bus.rd_valid), 0);
    @(negedge clk);
    #1 check_eq("rd_done_once", 32'(bus.done), 0);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b1;
    bus.rd_ready  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_ram_we", 32'(bus.ram_we), 0);
    check_eq("rst_wr_ready", 32'(bus.wr_ready), 0);
    check_eq("rst_rd_valid", 32'(bus.rd_valid), 0);
    check_eq("rst_done", 32'(bus.done), 0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 1);
    check_eq("rst_ram_addr", 32'(bus.ram_addr), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.wr_valid = 1'b0;
    #1 check_eq("post_rst_req_ready", 32'(bus.req_ready), 1);
    @(negedge clk);

    // fill RAM with 0..7, then read the whole RAM back with no stalls
    do_write(3'd0, 3'd7, 0, 0, -1);
    do_read(3'd0, 3'd7, 0, 0);

    // single write then single read
    do_write(3'd3, 3'd0, 0, 10, -1);
    do_read(3'd3, 3'd0, 0, 0);

    // wrapping write 6,7,0,1 and read back
    do_write(3'd6, 3'd3, 0, 10, -1);
    do_read(3'd6, 3'd3, 0, 0);

    // read backpressure on the first beat
    do_read(3'd0, 3'd1, 2, 5);

    // write with gaps 1,0,0,1,0,1
    do_write(3'd2, 3'd2, 2, -1, -1);
    do_read(3'd2, 3'd2, 0, 0);

    // reset after 2 beats of a 4-beat write, then check all of RAM
    do_write(3'd4, 3'd3, 0, 5, 2);
    do_read(3'd0, 3'd7, 0, 0);

    // random bursts
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(3'($urandom), 3'($urandom), int'($urandom_range(0, 1)), -1, -1);
      else
        do_read(3'($urandom), 3'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
